elevator_call_ctrl: RTL

Floor-call scheduler that sits directly upstream of the elevator light stage. It captures floor-button presses into a pending-request bitmap and tracks car position and direction. It sequences the car through travel and door phases using a collective (SCAN) policy. Its `call` output drives the light stage's `in` input, so the red/green indication follows car motion.

---
 rtl/elevator_call_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/elevator_call_ctrl.sv
// Floor-call scheduler with a collective (SCAN) policy. It captures button presses into a
// pending-request bitmap, moves the car one floor per TRAVEL_CYCLES and holds the door open
// for DOOR_CYCLES. The `call` output is high while the car is moving.
// Optional feature: define ELEVATOR_CALL_SYNC_EN to place a two-flop synchronizer ahead of
// button edge detection (press-to-req latency becomes 3 edges instead of 1).
module elevator_call_ctrl #(
  parameter int unsigned FLOORS        = 4,
  parameter int unsigned TRAVEL_CYCLES = 3,
  parameter int unsigned DOOR_CYCLES   = 4,
  localparam int unsigned FW           = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] btn,
  output logic [FLOORS-1:0] req,
  output logic [FW-1:0]     floor,
  output logic              dir_up,
  output logic              door_open,
  output logic              call
);

  localparam int unsigned TMax = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

  localparam logic [TW-1:0] TravelLast = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DoorLast   = TW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TopFloor   = FW'(FLOORS - 1);

`ifdef ELEVATOR_CALL_SYNC_EN
  localparam int unsigned ArmDepth = 3;
`else
  localparam int unsigned ArmDepth = 1;
`endif

  typedef enum logic [1:0] {StIdle, StMove, StArrive, StDoor} state_e;

  state_e            state;
  logic [TW-1:0]     timer;
  logic [FLOORS-1:0] btn_s;
  logic [FLOORS-1:0] btn_q;
  logic [ArmDepth-1:0] arm_q;
  logic              armed;

  logic [FLOORS-1:0] rise;
  logic [FLOORS-1:0] here;
  logic [FLOORS-1:0] above;
  logic [FLOORS-1:0] below;
  logic [FLOORS-1:0] set_mask;
  logic [FLOORS-1:0] req_d;
  logic              req_here;
  logic              req_ahead;
  logic              absorb;
  logic              clr_here;

`ifdef ELEVATOR_CALL_SYNC_EN
  logic [FLOORS-1:0] sync1;
  logic [FLOORS-1:0] sync2;

  // Two-flop synchronizer for asynchronous button levels
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign btn_s = sync2;
`else
  assign btn_s = btn;
`endif

  // Button history for rise detection; arm_q masks rises until the history is valid, so
  // buttons held through reset do not turn into phantom calls
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_q <= '0;
      arm_q <= '0;
    end else begin
      btn_q <= btn_s;
      arm_q <= (arm_q << 1) | ArmDepth'(1);
    end
  end

  assign armed = arm_q[ArmDepth-1];

  // Press decode, direction look-ahead and next request bitmap
  always_comb begin
    rise  = btn_s & ~btn_q & {FLOORS{armed}};
    here  = '0;
    here[floor] = 1'b1;
    above = '0;
    below = '0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      above[i] = (i > 32'(floor));
      below[i] = (i < 32'(floor));
    end
    req_here  = |(req & here);
    req_ahead = dir_up ? |(req & above) : |(req & below);
    // A press on the car's own floor is served on the spot when the car is parked or open
    absorb    = |(rise & here) && ((state == StIdle) || (state == StDoor));
    set_mask  = absorb ? (rise & ~here) : rise;
    clr_here  = ((state == StIdle) && (absorb || req_here)) ||
                ((state == StArrive) && req_here);
    // Clear first, then set: a fresh non-absorbed press on this floor survives the clear
    req_d     = (req & ~(clr_here ? here : '0)) | set_mask;
  end

  // Car FSM: state, timer, position, direction and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= StIdle;
      timer     <= '0;
      req       <= '0;
      floor     <= '0;
      dir_up    <= 1'b1;
      door_open <= 1'b0;
      call      <= 1'b0;
    end else begin
      req <= req_d;
      unique case (state)
        StIdle: begin
          timer <= '0;
          if (absorb || req_here) begin
            state     <= StDoor;
            door_open <= 1'b1;
          end else if (|req) begin
            // Nothing ahead means everything pending lies behind: turn around
            if (!req_ahead) begin
              dir_up <= ~dir_up;
            end
            state <= StMove;
            call  <= 1'b1;
          end
        end
        StMove: begin
          if (timer == TravelLast) begin
            timer <= '0;
            floor <= dir_up ? (floor + FW'(1)) : (floor - FW'(1));
            state <= StArrive;
            call  <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        StArrive: begin
          timer <= '0;
          if (req_here) begin
            state     <= StDoor;
            door_open <= 1'b1;
          end else if (req_ahead) begin
            state <= StMove;
            call  <= 1'b1;
          end else begin
            state <= StIdle;
          end
        end
        StDoor: begin
          if (timer == DoorLast) begin
            timer     <= '0;
            state     <= StIdle;
            door_open <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state     <= StIdle;
          timer     <= '0;
          door_open <= 1'b0;
          call      <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // The car never steps past the end floors
  step_in_bounds: assert property (@(posedge clk) disable iff (!reset)
    ((state == StMove) && (timer == TravelLast)) |->
      (dir_up ? (floor != TopFloor) : (floor != '0)));
`endif

endmodule
